// File: rtl/seven_seg_capture.sv
// seven_seg_capture: samples a multiplexed 4-digit seven-segment bus, waits
// for each digit to settle, decodes it and hands out whole frames.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   seven_segment  active-low segments {g,f,e,d,c,b,a}
//   dp             active-low decimal point
//   an             active-low anode enables, an[i]=0 selects digit i
//   out_digits     captured frame, digit i at [4i+3:4i]
//   out_dp         digit i had its decimal point lit
//   out_bad        digit i showed a pattern that is not a hex glyph
//   out_valid      frame available (held until out_ready)
//   out_ready      consumer accepts the frame
//   overrun        sticky: a frame completed while the output was blocked
//   stale          no anode activity for TIMEOUT cycles
module seven_seg_capture #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seven_segment,
    input  logic        dp,
    input  logic [3:0]  an,
    output logic [15:0] out_digits,
    output logic [3:0]  out_dp,
    output logic [3:0]  out_bad,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun,
    output logic        stale
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    SET = 8'(SETTLE);
    localparam logic [IW-1:0] TO  = IW'(TIMEOUT);

    // registered sample and the sample before it
    logic [3:0] an_q;
    logic [3:0] an_p;
    logic [6:0] seg_q;
    logic [6:0] seg_p;
    logic       dp_q;
    logic       dp_p;

    logic [7:0]    cnt;
    logic [7:0]    cnt_nxt;
    logic [IW-1:0] idle;
    logic [IW-1:0] idle_nxt;

    logic [15:0] slot_digits;
    logic [3:0]  slot_dp;
    logic [3:0]  slot_bad;
    logic [3:0]  seen;
    logic [3:0]  seen_upd;

    logic       sample_ok;
    logic       same;
    logic       cap;
    logic [3:0] cap_bit;
    logic [4:0] dec;
    logic       complete;
    logic       load;
    logic       ovr_set;

    // returns {bad, nibble}; unknown glyphs decode to 0 with bad set
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    always_comb begin
        sample_ok = 1'b0;
        case (an_q)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: sample_ok = 1'b1;
            default:                            sample_ok = 1'b0;
        endcase

        same = ({an_q, seg_q, dp_q} == {an_p, seg_p, dp_p});

        cnt_nxt = cnt;
        if (!sample_ok) begin
            cnt_nxt = 8'd0;
        end else if (!same) begin
            cnt_nxt = 8'd1;
        end else if (cnt != SET) begin
            cnt_nxt = cnt + 8'd1;
        end

        // fires only on the step into SET, so once per dwell
        cap     = sample_ok && (cnt_nxt == SET) && (cnt != SET);
        cap_bit = cap ? ~an_q : 4'b0000;
        dec     = decode(seg_q);

        seen_upd = seen | cap_bit;
        complete = (seen == 4'hF);
        load     = complete && (!out_valid || out_ready);
        // a capture that leaves a full frame behind a blocked output
        ovr_set  = cap && (&seen_upd) && out_valid && !out_ready;

        idle_nxt = idle;
        if (an_q != an_p) begin
            idle_nxt = '0;
        end else if (idle != TO) begin
            idle_nxt = idle + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q        <= 4'hF;
            an_p        <= 4'hF;
            seg_q       <= '0;
            seg_p       <= '0;
            dp_q        <= 1'b0;
            dp_p        <= 1'b0;
            cnt         <= '0;
            idle        <= '0;
            slot_digits <= '0;
            slot_dp     <= '0;
            slot_bad    <= '0;
            seen        <= '0;
            out_digits  <= '0;
            out_dp      <= '0;
            out_bad     <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            stale       <= 1'b0;
        end else begin
            an_q  <= an;
            seg_q <= seven_segment;
            dp_q  <= dp;
            an_p  <= an_q;
            seg_p <= seg_q;
            dp_p  <= dp_q;
            cnt   <= cnt_nxt;
            idle  <= idle_nxt;

            for (int i = 0; i < 4; i++) begin
                if (cap_bit[i]) begin
                    slot_digits[4*i +: 4] <= dec[3:0];
                    slot_dp[i]            <= ~dp_q;
                    slot_bad[i]           <= dec[4];
                end
            end

            seen <= (load ? 4'h0 : seen) | cap_bit;

            if (load) begin
                out_digits <= slot_digits;
                out_dp     <= slot_dp;
                out_bad    <= slot_bad;
                out_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            overrun <= overrun | ovr_set;

            if (idle_nxt == TO) begin
                stale <= 1'b1;
            end else if (cap) begin
                stale <= 1'b0;
            end
        end
    end

endmodule
